// File: rtl/dcache_pkg.sv
// Shared definitions for the set-associative data cache: controller states,
// default geometry and helpers that derive the address-field widths.
package dcache_pkg;

    // Controller states, kept as plain 2-bit constants
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_WB      = 2'd1;
    localparam state_t ST_FILL    = 2'd2;
    localparam state_t ST_INSTALL = 2'd3;

    // Default geometry: 2-way, 16 sets, 256-bit lines, 32-bit byte addresses
    localparam int DEF_WAYS   = 2;
    localparam int DEF_SETS   = 16;
    localparam int DEF_LINE_W = 256;
    localparam int DEF_ADDR_W = 32;

    // Byte-offset bits inside one line
    function automatic int offset_bits(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    // Set-index bits
    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    // Tag bits: whatever remains above index and offset
    function automatic int tag_bits(input int addr_w, input int sets, input int line_w);
        return addr_w - $clog2(sets) - $clog2(line_w / 8);
    endfunction

    // Way-number / LRU-age bits; a direct-mapped cache still gets one bit
    function automatic int age_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/dcache_lru.sv
// True-LRU bookkeeping: one age per way per set, 0 = most recently used,
// WAYS-1 = least recently used. Ages always form a permutation per set.
module dcache_lru
    import dcache_pkg::*;
#(
    parameter int WAYS = DEF_WAYS,
    parameter int SETS = DEF_SETS
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [index_bits(SETS)-1:0]   i_set,
    input  logic [age_bits(WAYS)-1:0]     i_touch_way,
    input  logic                          i_touch,
    output logic [age_bits(WAYS)-1:0]     o_victim
);
    localparam int AGE_W = age_bits(WAYS);

    logic [AGE_W-1:0] r_age [SETS][WAYS];

    // Touch: selected way becomes age 0, every way younger than it ages by one
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    r_age[s][w] <= AGE_W'(w);
        end else if (i_touch) begin
            for (int w = 0; w < WAYS; w++) begin
                if (AGE_W'(w) == i_touch_way)
                    r_age[i_set][w] <= '0;
                else if (r_age[i_set][w] < r_age[i_set][i_touch_way])
                    r_age[i_set][w] <= r_age[i_set][w] + 1'b1;
            end
        end
    end

    // Victim is the way carrying the oldest age in the addressed set
    always_comb begin
        o_victim = '0;
        for (int w = 0; w < WAYS; w++)
            if (r_age[i_set][w] == AGE_W'(WAYS - 1))
                o_victim = AGE_W'(w);
    end

endmodule

// File: rtl/dcache_assoc_ctrl.sv
// N-way set-associative, write-back, write-allocate L1 data cache controller.
// Hits complete in the lookup cycle; misses stall through optional writeback,
// refill and one install cycle, then the request is re-looked-up and hits.
module dcache_assoc_ctrl
    import dcache_pkg::*;
#(
    parameter int WAYS   = DEF_WAYS,
    parameter int SETS   = DEF_SETS,
    parameter int LINE_W = DEF_LINE_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);
    localparam int OFF_W  = offset_bits(LINE_W);
    localparam int WSEL_W = OFF_W - 2;
    localparam int IDX_W  = index_bits(SETS);
    localparam int TAG_W  = tag_bits(ADDR_W, SETS, LINE_W);
    localparam int WAY_W  = age_bits(WAYS);

    // Storage: flip-flop arrays, valid/dirty reset, tag/data left uninitialised
    logic              r_valid [WAYS][SETS];
    logic              r_dirty [WAYS][SETS];
    logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
    logic [LINE_W-1:0] r_data  [WAYS][SETS];

    // Miss-handling context
    state_t            r_state;
    logic [WAY_W-1:0]  r_victim;
    logic [IDX_W-1:0]  r_index;
    logic [TAG_W-1:0]  r_req_tag;
    logic [TAG_W-1:0]  r_wb_tag;
    logic [LINE_W-1:0] r_wb_line;
    logic [LINE_W-1:0] r_fill_line;

    logic [WSEL_W-1:0] w_word;
    logic [IDX_W-1:0]  w_index;
    logic [TAG_W-1:0]  w_tag;
    logic              w_req;
    logic [WAYS-1:0]   w_way_hit;
    logic [WAY_W-1:0]  w_hit_way;
    logic              w_lookup_hit;
    logic              w_miss;
    logic [LINE_W-1:0] w_hit_line;
    logic [WAY_W-1:0]  w_victim;
    logic [WAY_W-1:0]  w_lru_victim;
    logic              w_touch;
    logic [WAY_W-1:0]  w_touch_way;
    logic [IDX_W-1:0]  w_lru_set;
    logic              w_unused;

    assign w_word   = p1_addr_i[OFF_W-1:2];
    assign w_index  = p1_addr_i[OFF_W +: IDX_W];
    assign w_tag    = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign w_req    = p1_MemRead_i | p1_MemWrite_i;
    assign w_unused = ^p1_addr_i[1:0];

    // Parallel tag compare, one comparator per way
    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_hit
            assign w_way_hit[gi] = r_valid[gi][w_index] && (r_tag[gi][w_index] == w_tag);
        end
    endgenerate

    // Encode the hitting way (at most one way can match)
    always_comb begin
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (w_way_hit[w])
                w_hit_way = WAY_W'(w);
    end

    assign w_lookup_hit = rst_i && (r_state == ST_IDLE) && (|w_way_hit);
    assign w_miss       = rst_i && (r_state == ST_IDLE) && w_req && !(|w_way_hit);
    assign w_hit_line   = r_data[w_hit_way][w_index];

    assign p1_data_o  = (w_lookup_hit && w_req) ? w_hit_line[{w_word, 5'b0} +: 32] : 32'h0;
    assign p1_stall_o = rst_i && ((r_state != ST_IDLE) || w_miss);

    // Victim choice: lowest-index invalid way first, otherwise the LRU way
    always_comb begin
        w_victim = w_lru_victim;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!r_valid[w][w_index])
                w_victim = WAY_W'(w);
    end

    // A hit or an install makes the way MRU; install uses the latched set
    assign w_touch     = (w_lookup_hit && w_req) || (r_state == ST_INSTALL);
    assign w_touch_way = (r_state == ST_INSTALL) ? r_victim : w_hit_way;
    assign w_lru_set   = (r_state == ST_INSTALL) ? r_index  : w_index;

    dcache_lru #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_lru (
        .i_clk       (clk_i),
        .i_rst_n     (rst_i),
        .i_set       (w_lru_set),
        .i_touch_way (w_touch_way),
        .i_touch     (w_touch),
        .o_victim    (w_lru_victim)
    );

    // Miss FSM: latch victim context on a miss, sequence writeback and refill
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_victim    <= '0;
            r_index     <= '0;
            r_req_tag   <= '0;
            r_wb_tag    <= '0;
            r_wb_line   <= '0;
            r_fill_line <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_miss) begin
                        r_victim  <= w_victim;
                        r_index   <= w_index;
                        r_req_tag <= w_tag;
                        r_wb_tag  <= r_tag[w_victim][w_index];
                        r_wb_line <= r_data[w_victim][w_index];
                        r_state   <= (r_valid[w_victim][w_index] && r_dirty[w_victim][w_index])
                                     ? ST_WB : ST_FILL;
                    end
                end
                ST_WB: begin
                    if (mem_ack_i)
                        r_state <= ST_FILL;
                end
                ST_FILL: begin
                    if (mem_ack_i) begin
                        r_fill_line <= mem_data_i;
                        r_state     <= ST_INSTALL;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Valid/dirty: install clears dirty, a store hit sets it
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++) begin
                    r_valid[w][s] <= 1'b0;
                    r_dirty[w][s] <= 1'b0;
                end
        end else if (r_state == ST_INSTALL) begin
            r_valid[r_victim][r_index] <= 1'b1;
            r_dirty[r_victim][r_index] <= 1'b0;
        end else if (w_lookup_hit && p1_MemWrite_i) begin
            r_dirty[w_hit_way][w_index] <= 1'b1;
        end
    end

    // Tag/data: install writes the whole line, a store hit merges one word
    always_ff @(posedge clk_i) begin
        if (r_state == ST_INSTALL) begin
            r_tag[r_victim][r_index]  <= r_req_tag;
            r_data[r_victim][r_index] <= r_fill_line;
        end else if (w_lookup_hit && p1_MemWrite_i) begin
            r_data[w_hit_way][w_index][{w_word, 5'b0} +: 32] <= p1_data_i;
        end
    end

    // Memory port decoded from state so reset clears it immediately
    assign mem_enable_o = (r_state == ST_WB) || (r_state == ST_FILL);
    assign mem_write_o  = (r_state == ST_WB);
    assign mem_addr_o   = (r_state == ST_WB)   ? {r_wb_tag,  r_index, {OFF_W{1'b0}}} :
                          (r_state == ST_FILL) ? {r_req_tag, r_index, {OFF_W{1'b0}}} :
                          '0;
    assign mem_data_o   = (r_state == ST_WB) ? r_wb_line : '0;

endmodule
